fpu_arbiter: RTL

FPU_ARBITER -- requirements
Module: fpu_arbiter

---
 rtl/fpu_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU among four requesters.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> DONE.
module fpu_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk_operation,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [11:0]  req_op,
    input  logic [7:0]   req_rmode,
    input  logic [255:0] req_opa,
    input  logic [255:0] req_opb,
    output logic [3:0]   gnt,
    output logic [3:0]   done,
    output logic [63:0]  result,
    output logic         timeout,
    output logic         busy,
    output logic         fpu_enable,
    output logic [2:0]   fpu_op,
    output logic [1:0]   fpu_rmode,
    output logic [63:0]  fpu_opa,
    output logic [63:0]  fpu_opb,
    input  logic [63:0]  fpu_out,
    input  logic         fpu_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [3:0]    done_q, done_d;
    logic [63:0]   result_q, result_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;
    logic          fpu_enable_q, fpu_enable_d;
    logic [2:0]    fpu_op_q, fpu_op_d;
    logic [1:0]    fpu_rmode_q, fpu_rmode_d;
    logic [63:0]   fpu_opa_q, fpu_opa_d;
    logic [63:0]   fpu_opb_q, fpu_opb_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          armed_q, armed_d;

    logic          found;
    logic [1:0]    win;
    logic [1:0]    cand;
    logic [2:0]    sel_op;
    logic [1:0]    sel_rmode;
    logic [63:0]   sel_opa;
    logic [63:0]   sel_opb;

    // Search starts just after the last winner, so the last winner is checked last.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_rmode = '0;
        sel_opa   = '0;
        sel_opb   = '0;
        for (int i = 0; i < 4; i++) begin
            if (win == 2'(i)) begin
                sel_op    = req_op[3*i +: 3];
                sel_rmode = req_rmode[2*i +: 2];
                sel_opa   = req_opa[64*i +: 64];
                sel_opb   = req_opb[64*i +: 64];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        done_d       = '0;
        result_d     = result_q;
        timeout_d    = 1'b0;
        fpu_enable_d = 1'b0;
        fpu_op_d     = fpu_op_q;
        fpu_rmode_d  = fpu_rmode_q;
        fpu_opa_d    = fpu_opa_q;
        fpu_opb_d    = fpu_opb_q;
        wait_cnt_d   = wait_cnt_q;
        armed_d      = armed_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d      = S_ISSUE;
                    ptr_d        = win;
                    gnt_d        = 4'b0001 << win;
                    fpu_enable_d = 1'b1;
                    fpu_op_d     = sel_op;
                    fpu_rmode_d  = sel_rmode;
                    fpu_opa_d    = sel_opa;
                    fpu_opb_d    = sel_opb;
                end
            end
            S_ISSUE: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
                armed_d    = 1'b0;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + CW'(1);
                // A ready level only counts once the FPU has been seen low.
                if (!fpu_ready) begin
                    armed_d = 1'b1;
                end
                if (armed_q && fpu_ready) begin
                    state_d  = S_DONE;
                    result_d = fpu_out;
                    done_d   = gnt_q;
                end else if (wait_cnt_d == CNT_MAX) begin
                    state_d   = S_DONE;
                    result_d  = '0;
                    timeout_d = 1'b1;
                    done_d    = gnt_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= 2'd3;
            gnt_q        <= '0;
            done_q       <= '0;
            result_q     <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            fpu_enable_q <= 1'b0;
            fpu_op_q     <= '0;
            fpu_rmode_q  <= '0;
            fpu_opa_q    <= '0;
            fpu_opb_q    <= '0;
            wait_cnt_q   <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            fpu_enable_q <= fpu_enable_d;
            fpu_op_q     <= fpu_op_d;
            fpu_rmode_q  <= fpu_rmode_d;
            fpu_opa_q    <= fpu_opa_d;
            fpu_opb_q    <= fpu_opb_d;
            wait_cnt_q   <= wait_cnt_d;
            armed_q      <= armed_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign result     = result_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;
    assign fpu_enable = fpu_enable_q;
    assign fpu_op     = fpu_op_q;
    assign fpu_rmode  = fpu_rmode_q;
    assign fpu_opa    = fpu_opa_q;
    assign fpu_opb    = fpu_opb_q;

endmodule
